pll_dyn_ctrl: RTL and testbench
===============================

PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_PROFILES, 4, number of divider profiles (2..8).
- NUM_OUT, 3, number of controlled PLL outputs (1..7).
- PROFILE_IDIV, packed NUM_PROFILES x 6b, IDSEL encoding per profile; profile 0 in the LSBs.
- PROFILE_MDIV, packed NUM_PROFILES x 7b, MDSEL encoding per profile.
- PROFILE_ODIV, packed NUM_PROFILES x NUM_OUT x 7b, ODSELn encoding per profile and output; output 0 in the LSBs of each profile.
- DEFAULT_PROFILE, 0, profile applied after reset.
- RESET_CYCLES, 16, PLL reset pulse length in clk cycles.
- GATE_CYCLES, 4, clk_en-low settle time before and after a divider change.
- LOCK_STABLE, 64, consecutive synchronised lock cycles required.
- LOCK_TIMEOUT, 4096, WAIT_LOCK cycles before a retry.
- MAX_RETRY, 2, retries before FAIL.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, free-running reference clock; SHALL NOT be a PLL output.
- resetn, in, 1, asynchronous active-low reset.
- req, in, 1, single-cycle request to switch profile.
- req_profile, in, clog2(NUM_PROFILES), profile index sampled with req.
- pll_lock, in, 1, PLL LOCK; asynchronous to clk.
- pll_reset, out, 1, drives PLL RESET.
- idsel, out, 6; mdsel, out, 7; odsel, out, NUM_OUT*7: dynamic divider selects, passed verbatim from the tables.
- clk_en, out, NUM_OUT, drives ENCLKn.
- busy, out, 1; locked, out, 1; error, out, 1 (sticky); bad_req, out, 1 (one-cycle pulse).
- cur_profile, out, clog2(NUM_PROFILES), profile currently driven.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchroniser before use; every lock timing below refers to the synchronised value.
REQ-004 States SHALL be GATE, APPLY, WAIT_LOCK, UNGATE, READY and FAIL.
REQ-005 GATE: clk_en=0 and dividers unchanged for GATE_CYCLES cycles; then go to APPLY.
REQ-006 APPLY:
- idsel, mdsel, odsel and cur_profile SHALL update on the first cycle of APPLY.
- pll_reset=1 for exactly RESET_CYCLES cycles; then go to WAIT_LOCK with pll_reset=0.
REQ-007 WAIT_LOCK:
- A stable counter SHALL count consecutive lock=1 cycles and clear on any lock=0 cycle.
- When the count reaches LOCK_STABLE, go to UNGATE.
- If LOCK_TIMEOUT cycles elapse first and retries < MAX_RETRY: increment retries, go to APPLY.
- Otherwise go to FAIL.
REQ-008 UNGATE: clk_en=0 for GATE_CYCLES cycles; then go to READY.
REQ-009 READY: clk_en all 1, locked=1, busy=0.
REQ-010 busy SHALL be 1 in every state except READY and FAIL.
REQ-011 FAIL:
- error=1 (sticky), pll_reset=0, clk_en=0, locked=0.
- Exited only by an accepted req (to GATE) or by reset.
REQ-012 Lock loss in READY: a lock=0 cycle SHALL clear locked and clk_en on the next cycle and go to WAIT_LOCK with the timeout counter cleared and retries=0; dividers are unchanged.
REQ-013 A req with req_profile >= NUM_PROFILES SHALL be ignored and SHALL pulse bad_req for one cycle.
REQ-014 A valid req in READY or FAIL SHALL go to GATE on the next cycle and clear retries; error stays set.
REQ-015 A valid req while busy SHALL be held in a one-deep pending register, with the latest request overwriting an earlier one. The pending request is serviced on the cycle READY or FAIL is entered, and READY is then held for exactly one cycle.
REQ-016 A req equal to cur_profile SHALL still perform the full sequence.
REQ-017 All counters SHALL saturate, and no counter SHALL wrap.

Reset
REQ-018 While resetn=0, outputs SHALL be:
- pll_reset=1, clk_en=0, busy=1.
- locked=0, error=0, bad_req=0.
- Dividers and cur_profile = DEFAULT_PROFILE.
- Pending request and retries cleared; state=APPLY with its counter at 0.
REQ-019 On resetn release, the sequence SHALL continue from APPLY (REQ-006).
REQ-020 A reset asserted mid-sequence SHALL abort the sequence and discard any pending request.

Verification
REQ-021 Reset, then pll_lock rises 100 cycles after pll_reset falls -> pll_reset high 16 cycles after release; locked=1 and clk_en=3'b111 exactly 2+64+4 cycles after the lock rise.
REQ-022 READY on profile 0, req with req_profile=2 -> clk_en=0 next cycle; 4 cycles later mdsel/odsel equal the profile-2 entries and pll_reset is high for 16 cycles; cur_profile=2.
REQ-023 pll_lock held 0 -> three pll_reset pulses (initial plus 2 retries), each 16 cycles, separated by 4096-cycle waits; then error=1 and busy=0. A later req=1 recovers to READY with error still 1.
REQ-024 Lock glitches low for 1 cycle at stable count 50 -> count restarts; READY is reached 64 stable cycles after the glitch.
REQ-025 req_profile=5 -> bad_req pulses once, no state change. req to 1 then req to 3 while busy -> exactly one further sequence, ending with cur_profile=3.
REQ-026 Lock drops for 10 cycles in READY -> locked=0 and clk_en=0 within 1 cycle plus synchroniser delay, no pll_reset pulse, READY regained after relock.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL divider controller: gates outputs, reprograms dividers, pulses PLL reset, waits for stable lock.
// Latency: GATE_CYCLES + RESET_CYCLES + 2 (sync) + LOCK_STABLE + GATE_CYCLES cycles from request to READY.
// Backpressure: requests arriving while busy land in a one-deep pending slot (latest wins), serviced on READY/FAIL entry.
module pll_dyn_ctrl #(
   parameter int NUM_PROFILES    = 4,
   parameter int NUM_OUT         = 3,
   parameter logic [NUM_PROFILES*6-1:0]         PROFILE_IDIV = {NUM_PROFILES{6'd1}},
   parameter logic [NUM_PROFILES*7-1:0]         PROFILE_MDIV = {NUM_PROFILES{7'd1}},
   parameter logic [NUM_PROFILES*NUM_OUT*7-1:0] PROFILE_ODIV = {(NUM_PROFILES*NUM_OUT){7'd1}},
   parameter int DEFAULT_PROFILE = 0,
   parameter int RESET_CYCLES    = 16,
   parameter int GATE_CYCLES     = 4,
   parameter int LOCK_STABLE     = 64,
   parameter int LOCK_TIMEOUT    = 4096,
   parameter int MAX_RETRY       = 2
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              req,
   input  logic [$clog2(NUM_PROFILES)-1:0]   req_profile,
   input  logic                              pll_lock,
   output logic                              pll_reset,
   output logic [5:0]                        idsel,
   output logic [6:0]                        mdsel,
   output logic [NUM_OUT*7-1:0]              odsel,
   output logic [NUM_OUT-1:0]                clk_en,
   output logic                              busy,
   output logic                              locked,
   output logic                              error,
   output logic                              bad_req,
   output logic [$clog2(NUM_PROFILES)-1:0]   cur_profile
);

   localparam int PW        = $clog2(NUM_PROFILES);
   localparam int OW        = NUM_OUT * 7;
   localparam int CNT_TOP_A = (RESET_CYCLES > GATE_CYCLES) ? RESET_CYCLES : GATE_CYCLES;
   localparam int CNT_TOP   = (LOCK_TIMEOUT > CNT_TOP_A) ? LOCK_TIMEOUT : CNT_TOP_A;
   localparam int CW        = $clog2(CNT_TOP + 1);
   localparam int SW        = $clog2(LOCK_STABLE + 1);
   localparam int RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
   localparam logic [PW-1:0] DEF_PROF  = PW'(DEFAULT_PROFILE);

   typedef enum logic [2:0] {
      S_GATE,
      S_APPLY,
      S_WAIT_LOCK,
      S_UNGATE,
      S_READY,
      S_FAIL
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_inc;
   logic [SW-1:0]   stab;
   logic [SW-1:0]   stab_inc;
   logic [RW-1:0]   retries;
   logic [PW-1:0]   tgt;
   logic            pend_vld;
   logic [PW-1:0]   pend_prof;
   logic            lock_meta;
   logic            lock_s;
   logic            req_ok;
   logic            idle;
   logic            start;
   logic [PW-1:0]   start_prof;

   // Per-profile divider tables unpacked from the parameter vectors
   logic [5:0]      idiv_tab [NUM_PROFILES];
   logic [6:0]      mdiv_tab [NUM_PROFILES];
   logic [OW-1:0]   odiv_tab [NUM_PROFILES];

   for (genvar p = 0; p < NUM_PROFILES; p++) begin : g_tab
      assign idiv_tab[p] = PROFILE_IDIV[p*6 +: 6];
      assign mdiv_tab[p] = PROFILE_MDIV[p*7 +: 7];
      assign odiv_tab[p] = PROFILE_ODIV[p*OW +: OW];
   end

   // Counters hold at all-ones rather than wrapping
   assign cnt_inc  = (cnt == '1)  ? cnt  : cnt + 1'b1;
   assign stab_inc = (stab == '1) ? stab : stab + 1'b1;

   assign req_ok     = req && (int'(req_profile) < NUM_PROFILES);
   assign idle       = (state == S_READY) || (state == S_FAIL);
   assign start      = idle && (req_ok || pend_vld);
   assign start_prof = req_ok ? req_profile : pend_prof;

   // Two-flop synchroniser for the asynchronous PLL lock indicator
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // One-deep pending slot: latest valid request while busy wins, consumed when idle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_vld  <= 1'b0;
         pend_prof <= '0;
      end else if (req_ok && !idle) begin
         pend_vld  <= 1'b1;
         pend_prof <= req_profile;
      end else if (start) begin
         pend_vld  <= 1'b0;
      end
   end

   // Sequencing FSM with registered outputs; reset parks it in APPLY with PLL reset asserted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_APPLY;
         cnt         <= '0;
         stab        <= '0;
         retries     <= '0;
         tgt         <= DEF_PROF;
         cur_profile <= DEF_PROF;
         idsel       <= idiv_tab[DEF_PROF];
         mdsel       <= mdiv_tab[DEF_PROF];
         odsel       <= odiv_tab[DEF_PROF];
         pll_reset   <= 1'b1;
         clk_en      <= '0;
         busy        <= 1'b1;
         locked      <= 1'b0;
         error       <= 1'b0;
         bad_req     <= 1'b0;
      end else begin
         bad_req <= req && !req_ok;
         case (state)
            S_GATE: begin
               if (cnt == GATE_LAST) begin
                  state       <= S_APPLY;
                  cnt         <= '0;
                  cur_profile <= tgt;
                  idsel       <= idiv_tab[tgt];
                  mdsel       <= mdiv_tab[tgt];
                  odsel       <= odiv_tab[tgt];
                  pll_reset   <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_APPLY: begin
               if (cnt == RST_LAST) begin
                  state     <= S_WAIT_LOCK;
                  cnt       <= '0;
                  stab      <= '0;
                  pll_reset <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s && (stab == STAB_LAST)) begin
                  state <= S_UNGATE;
                  cnt   <= '0;
                  stab  <= '0;
               end else if (cnt == TO_LAST) begin
                  cnt  <= '0;
                  stab <= '0;
                  if (int'(retries) < MAX_RETRY) begin
                     retries   <= retries + 1'b1;
                     state     <= S_APPLY;
                     pll_reset <= 1'b1;
                  end else begin
                     state <= S_FAIL;
                     busy  <= 1'b0;
                     error <= 1'b1;
                  end
               end else begin
                  cnt  <= cnt_inc;
                  stab <= lock_s ? stab_inc : '0;
               end
            end
            S_UNGATE: begin
               if (cnt == GATE_LAST) begin
                  state  <= S_READY;
                  cnt    <= '0;
                  clk_en <= '1;
                  locked <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_READY, S_FAIL: begin
               if (start) begin
                  state   <= S_GATE;
                  cnt     <= '0;
                  tgt     <= start_prof;
                  retries <= '0;
                  clk_en  <= '0;
                  locked  <= 1'b0;
                  busy    <= 1'b1;
               end else if ((state == S_READY) && !lock_s) begin
                  // Lock lost: re-qualify lock on the same dividers, no PLL reset
                  state   <= S_WAIT_LOCK;
                  cnt     <= '0;
                  stab    <= '0;
                  retries <= '0;
                  clk_en  <= '0;
                  locked  <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            default: begin
               state <= S_FAIL;
               busy  <= 1'b0;
               error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: reset, profile switch, retries/fail, glitches, pending and bad requests.
// Inputs are driven 1 time unit after the rising edge, outputs sampled at the same point.
// PLL lock is modelled by hand-driven pll_lock.
module tb_pll_dyn_ctrl;

   localparam int NP = 5;
   localparam int NO = 3;
   localparam logic [NP*6-1:0]    T_IDIV = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
   localparam logic [NP*7-1:0]    T_MDIV = {7'd50, 7'd40, 7'd30, 7'd20, 7'd10};
   localparam logic [NP*NO*7-1:0] T_ODIV = {7'd43, 7'd42, 7'd41, 7'd33, 7'd32, 7'd31,
                                            7'd23, 7'd22, 7'd21, 7'd13, 7'd12, 7'd11,
                                            7'd3,  7'd2,  7'd1};

   logic          clk = 1'b0;
   logic          resetn;
   logic          req;
   logic [2:0]    req_profile;
   logic          pll_lock;
   logic          pll_reset;
   logic [5:0]    idsel;
   logic [6:0]    mdsel;
   logic [NO*7-1:0] odsel;
   logic [NO-1:0] clk_en;
   logic          busy;
   logic          locked;
   logic          error;
   logic          bad_req;
   logic [2:0]    cur_profile;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;
   int n_bad   = 0;
   int hi_len  = 0;
   int last_len = 0;
   logic prev_rst = 1'b0;

   pll_dyn_ctrl #(
      .NUM_PROFILES (NP),
      .NUM_OUT      (NO),
      .PROFILE_IDIV (T_IDIV),
      .PROFILE_MDIV (T_MDIV),
      .PROFILE_ODIV (T_ODIV)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .req_profile (req_profile),
      .pll_lock    (pll_lock),
      .pll_reset   (pll_reset),
      .idsel       (idsel),
      .mdsel       (mdsel),
      .odsel       (odsel),
      .clk_en      (clk_en),
      .busy        (busy),
      .locked      (locked),
      .error       (error),
      .bad_req     (bad_req),
      .cur_profile (cur_profile)
   );

   always #5 clk = ~clk;

   // Pulse counter and pulse-length tracker for pll_reset, plus bad_req pulse count
   always @(negedge clk) begin
      if (pll_reset) begin
         hi_len = hi_len + 1;
      end else begin
         if (prev_rst) last_len = hi_len;
         hi_len = 0;
      end
      if (pll_reset && !prev_rst) n_pulse = n_pulse + 1;
      prev_rst = pll_reset;
      if (bad_req) n_bad = n_bad + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rst(input logic level, input int budget, output int n);
      n = 0;
      while (pll_reset !== level && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_locked(input int budget, output int n);
      n = 0;
      while (locked !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic send_req(input logic [2:0] prof);
      req = 1'b1;
      req_profile = prof;
      tick();
      req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int p0;
      int b0;
      resetn = 1'b0;
      req = 1'b0;
      req_profile = 3'd0;
      pll_lock = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_pll_reset", pll_reset, 1);
      check("rst_clk_en", clk_en, 0);
      check("rst_busy", busy, 1);
      check("rst_locked", locked, 0);
      check("rst_error", error, 0);
      check("rst_bad_req", bad_req, 0);
      check("rst_idsel", idsel, 1);
      check("rst_mdsel", mdsel, 10);
      check("rst_odsel", odsel, {7'd3, 7'd2, 7'd1});
      check("rst_cur", cur_profile, 0);

      // Release: 16-cycle PLL reset, lock 100 cycles later, READY 70 cycles after lock rise
      resetn = 1'b1;
      wait_rst(1'b0, 100, n);
      check("init_rst_len", n, 16);
      repeat (100) tick();
      check("init_waiting_busy", busy, 1);
      pll_lock = 1'b1;
      wait_locked(200, n);
      check("init_lock_latency", n, 70);
      check("init_clk_en", clk_en, 3'b111);
      check("init_busy", busy, 0);

      // Switch to profile 2
      pll_lock = 1'b0;
      send_req(3'd2);
      check("sw_clk_en_off", clk_en, 0);
      check("sw_busy", busy, 1);
      check("sw_mdsel_held", mdsel, 10);
      repeat (3) tick();
      check("sw_gate_mdsel", mdsel, 10);
      check("sw_gate_no_rst", pll_reset, 0);
      tick();
      check("sw_apply_rst", pll_reset, 1);
      check("sw_idsel", idsel, 3);
      check("sw_mdsel", mdsel, 30);
      check("sw_odsel", odsel, {7'd23, 7'd22, 7'd21});
      check("sw_cur", cur_profile, 2);
      wait_rst(1'b0, 100, n);
      tick();
      check("sw_rst_pulse_len", last_len, 16);
      repeat (5) tick();
      pll_lock = 1'b1;
      wait_locked(200, n);
      check("sw_lock_latency", n, 70);

      // Lock glitch at stable count 50 restarts the stable count
      pll_lock = 1'b0;
      send_req(3'd1);
      wait_rst(1'b1, 50, n);
      wait_rst(1'b0, 50, n);
      repeat (5) tick();
      pll_lock = 1'b1;
      repeat (50) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      wait_locked(300, n);
      check("glitch_lock_latency", n, 70);
      check("glitch_cur", cur_profile, 1);
      check("glitch_odsel", odsel, {7'd13, 7'd12, 7'd11});

      // Out-of-range request
      b0 = n_bad;
      p0 = n_pulse;
      send_req(3'd5);
      check("bad_pulse", bad_req, 1);
      check("bad_busy", busy, 0);
      check("bad_cur", cur_profile, 1);
      tick();
      check("bad_pulse_end", bad_req, 0);
      check("bad_count", n_bad - b0, 1);
      check("bad_no_rst", n_pulse - p0, 0);

      // Requests while busy: pending slot keeps only the latest
      p0 = n_pulse;
      pll_lock = 1'b0;
      send_req(3'd4);
      repeat (2) tick();
      send_req(3'd1);
      send_req(3'd3);
      wait_rst(1'b0, 100, n);
      pll_lock = 1'b1;
      wait_locked(300, n);
      check("pend_first_cur", cur_profile, 4);
      check("pend_first_mdsel", mdsel, 50);
      tick();
      check("pend_ready_1cyc_busy", busy, 1);
      check("pend_ready_1cyc_en", clk_en, 0);
      wait_locked(300, n);
      check("pend_final_cur", cur_profile, 3);
      check("pend_final_mdsel", mdsel, 40);
      check("pend_final_odsel", odsel, {7'd33, 7'd32, 7'd31});
      repeat (20) tick();
      check("pend_stays_ready", busy, 0);
      check("pend_seq_count", n_pulse - p0, 2);

      // Lock loss in READY for 10 cycles
      p0 = n_pulse;
      pll_lock = 1'b0;
      repeat (2) tick();
      check("loss_sync_delay", locked, 1);
      tick();
      check("loss_locked", locked, 0);
      check("loss_clk_en", clk_en, 0);
      check("loss_busy", busy, 1);
      repeat (7) tick();
      pll_lock = 1'b1;
      wait_locked(200, n);
      check("loss_relock_latency", n, 70);
      check("loss_no_rst", n_pulse - p0, 0);
      check("loss_cur", cur_profile, 3);

      // Reset mid-sequence drops the pending request
      pll_lock = 1'b0;
      send_req(3'd1);
      repeat (2) tick();
      send_req(3'd3);
      resetn = 1'b0;
      #1;
      check("midrst_pll_reset", pll_reset, 1);
      check("midrst_cur", cur_profile, 0);
      check("midrst_busy", busy, 1);
      tick();
      resetn = 1'b1;
      pll_lock = 1'b1;
      wait_locked(300, n);
      check("midrst_locked", locked, 1);
      repeat (20) tick();
      check("midrst_no_pending", busy, 0);
      check("midrst_cur_final", cur_profile, 0);

      // Lock never arrives: initial pulse plus two retries, then FAIL
      pll_lock = 1'b0;
      send_req(3'd0);
      p0 = n_pulse;
      wait_rst(1'b1, 20, n);
      check("fail_gate_len", n, 4);
      for (int r = 0; r < 3; r++) begin
         wait_rst(1'b0, 100, n);
         check("fail_rst_len", n, 16);
         if (r < 2) begin
            wait_rst(1'b1, 5000, n);
            check("fail_timeout_len", n, 4096);
         end
      end
      wait_idle(5000, n);
      check("fail_last_timeout", n, 4096);
      check("fail_error", error, 1);
      check("fail_pll_reset", pll_reset, 0);
      check("fail_clk_en", clk_en, 0);
      check("fail_locked", locked, 0);
      check("fail_pulses", n_pulse - p0, 3);
      repeat (10) tick();
      check("fail_sticky", error, 1);
      check("fail_stays_idle", busy, 0);
      pll_lock = 1'b1;
      send_req(3'd2);
      check("recover_busy", busy, 1);
      wait_locked(300, n);
      check("recover_locked", locked, 1);
      check("recover_error_kept", error, 1);
      check("recover_busy_low", busy, 0);
      check("recover_cur", cur_profile, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
